// File: rtl/arm_imm_encoder.sv
// Inverse immediate extender: maps a target ExtImm value and ImmSrc back to the 24-bit field.
// Define ARM_IMM_ROT_SEARCH_EN to enable the multi-cycle rotate search for mode 00.
module arm_imm_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] imm_field,
    output logic        fail
);

    if (ROT_STEPS < 1 || ROT_STEPS > 16) begin : g_bad_rot_steps
        $error("ROT_STEPS must be in 1..16");
    end

`ifdef ARM_IMM_ROT_SEARCH_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

    function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] w;
        w = {v, v} << {r, 1'b0};
        return w[63:32];
    endfunction

    logic [31:0] val_q, val_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] cand;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [23:0] imm_q, imm_d;
    logic        fail_q, fail_d;
    logic        br_ok;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign imm_field = imm_q;
    assign fail      = fail_q;

    // Branch offsets must be word aligned and fit a signed 26-bit byte offset.
    assign br_ok = (value[1:0] == 2'b00) && (value[31:26] == {6{value[25]}});

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        fail_d  = fail_q;
`ifdef ARM_IMM_ROT_SEARCH_EN
        val_d   = val_q;
        rot_d   = rot_q;
        cand    = rol2(val_q, rot_q);
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    unique case (imm_src)
                        2'b00: begin
`ifdef ARM_IMM_ROT_SEARCH_EN
                            // Rotation 0 is tested on the accept edge itself.
                            val_d = value;
                            if (value[31:8] == 24'd0) begin
                                fail_d = 1'b0;
                                imm_d  = {16'd0, value[7:0]};
                            end else if (ROT_STEPS == 1) begin
                                fail_d = 1'b1;
                                imm_d  = 24'd0;
                            end else begin
                                state_d = SEARCH;
                                rot_d   = 4'd1;
                            end
`else
                            fail_d = |value[31:8];
                            imm_d  = fail_d ? 24'd0 : {16'd0, value[7:0]};
`endif
                        end
                        2'b01: begin
                            fail_d = |value[31:12];
                            imm_d  = fail_d ? 24'd0 : {12'd0, value[11:0]};
                        end
                        2'b10: begin
                            fail_d = !br_ok;
                            imm_d  = br_ok ? value[25:2] : 24'd0;
                        end
                        2'b11: begin
                            fail_d = 1'b1;
                            imm_d  = 24'd0;
                        end
                    endcase
                end
            end
`ifdef ARM_IMM_ROT_SEARCH_EN
            SEARCH: begin
                if (cand[31:8] == 24'd0) begin
                    state_d = DONE;
                    fail_d  = 1'b0;
                    imm_d   = {12'd0, rot_q, cand[7:0]};
                end else if (rot_q == ROT_LAST) begin
                    state_d = DONE;
                    fail_d  = 1'b1;
                    imm_d   = 24'd0;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef ARM_IMM_ROT_SEARCH_EN
                    rot_d   = 4'd0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            imm_q   <= 24'd0;
            fail_q  <= 1'b0;
`ifdef ARM_IMM_ROT_SEARCH_EN
            val_q   <= 32'd0;
            rot_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            fail_q  <= fail_d;
`ifdef ARM_IMM_ROT_SEARCH_EN
            val_q   <= val_d;
            rot_q   <= rot_d;
`endif
        end
    end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Scoreboard bench for arm_imm_encoder: directed requests, latency and round-trip checks.
// Expectations follow ARM_IMM_ROT_SEARCH_EN when it is defined for the build.
module tb_arm_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] imm_field;
    logic        fail;

`ifdef ARM_IMM_ROT_SEARCH_EN
    localparam bit SRCH = 1'b1;
`else
    localparam bit SRCH = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [1:0]  src;
        logic [31:0] val;
        logic [23:0] imm;
        logic        fail;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    arm_imm_encoder #(.ROT_STEPS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_field (imm_field),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    // Forward extender, used to confirm encoded fields expand back to the target.
    function automatic logic [31:0] ext(input logic [1:0] s, input logic [23:0] im);
        logic [63:0] w;
        logic [4:0]  sh;
        case (s)
            2'b00: begin
                sh = {im[11:8], 1'b0};
                w  = {24'd0, im[7:0], 24'd0, im[7:0]} >> sh;
                return w[31:0];
            end
            2'b01:   return {20'd0, im[11:0]};
            2'b10:   return {{6{im[23]}}, im, 2'b00};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] s, input logic [31:0] v,
                        input logic [23:0] im, input logic f, input int lat);
        exp_t e;
        e.tag = tag; e.src = s; e.val = v; e.imm = im; e.fail = f; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drive(input string tag, input logic [1:0] s, input logic [31:0] v);
        check({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        imm_src  = s;
        value    = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        value    = $urandom();
    endtask

    task automatic collect(input int hold);
        exp_t        e;
        int          k;
        logic [23:0] im0;
        logic        f0;
        k = 1;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        e = sb.pop_front();
        check({e.tag, "_valid"}, 32'(out_valid), 32'd1);
        check({e.tag, "_lat"}, 32'(k), 32'(e.lat));
        check({e.tag, "_imm"}, 32'(imm_field), 32'(e.imm));
        check({e.tag, "_fail"}, 32'(fail), 32'(e.fail));
        check({e.tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
        if (!e.fail && !fail)
            check({e.tag, "_roundtrip"}, ext(e.src, imm_field), e.val);
        im0 = imm_field;
        f0  = fail;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            value    = $urandom();
            @(posedge clk); #1;
            check({e.tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({e.tag, "_hold_imm"}, 32'(imm_field), 32'(im0));
            check({e.tag, "_hold_fail"}, 32'(fail), 32'(f0));
            check({e.tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({e.tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        check({e.tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] s, input logic [31:0] v,
                       input logic [23:0] im, input logic f, input int lat, input int hold);
        push(tag, s, v, im, f, lat);
        drive(tag, s, v);
        collect(hold);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        value     = 32'd0;
        imm_src   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_imm", 32'(imm_field), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        reset = 1'b0;

        // Stray out_ready while idle does nothing.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_ordy_rdy", 32'(in_ready), 32'd1);
        check("idle_ordy_valid", 32'(out_valid), 32'd0);

        run("dp_ab", 2'b00, 32'h0000_00AB, 24'h0000AB, 1'b0, 1, 0);
        run("dp_ff000000", 2'b00, 32'hFF00_0000,
            SRCH ? 24'h0004FF : 24'h0, !SRCH, SRCH ? 5 : 1, 0);
        run("dp_101", 2'b00, 32'h0000_0101, 24'h0, 1'b1, SRCH ? 16 : 1, 0);
        run("dp_zero", 2'b00, 32'h0, 24'h0, 1'b0, 1, 0);
        run("dp_c000003f", 2'b00, 32'hC000_003F,
            SRCH ? 24'h0001FF : 24'h0, !SRCH, SRCH ? 2 : 1, 0);
        run("dp_100", 2'b00, 32'h0000_0100,
            SRCH ? 24'h000C01 : 24'h0, !SRCH, SRCH ? 13 : 1, 0);
        run("br_neg", 2'b10, 32'hFFFF_FFF8, 24'hFFFFFE, 1'b0, 1, 0);
        run("br_unal", 2'b10, 32'h0000_0006, 24'h0, 1'b1, 1, 0);
        run("br_maxpos", 2'b10, 32'h01FF_FFFC, 24'h7FFFFF, 1'b0, 1, 0);
        run("br_ovf", 2'b10, 32'h0200_0000, 24'h0, 1'b1, 1, 0);
        run("i12_ovf", 2'b01, 32'h0000_1000, 24'h0, 1'b1, 1, 0);
        run("i12_max", 2'b01, 32'h0000_0FFF, 24'h000FFF, 1'b0, 1, 0);
        run("i12_abc", 2'b01, 32'h0000_0ABC, 24'h000ABC, 1'b0, 1, 0);
        run("inv", 2'b11, 32'h0000_0001, 24'h0, 1'b1, 1, 0);

        // Backpressure: result held for 10 cycles while in_valid pulses.
        run("bp", 2'b10, 32'h0000_0400, 24'h000100, 1'b0, 1, 10);

        // Reset three cycles into a long request discards it.
        drive("rst_mid", 2'b00, 32'h0000_0101);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_rdy", 32'(in_ready), 32'd1);
        check("rst_mid_imm", 32'(imm_field), 32'd0);
        check("rst_mid_fail", 32'(fail), 32'd0);

        run("dp_3f0", 2'b00, 32'h0000_03F0,
            SRCH ? 24'h000E3F : 24'h0, !SRCH, SRCH ? 15 : 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
